// File: rtl/zle_xc9_fsm_if.sv
// Control/status bundle between the zero run-length encoder FSM and its
// surroundings (stream fabric on one side, zle_xc9_dp on the other).
//   i_valid/i_ready  : input stream handshake (token visible on dp i_d)
//   o_valid/o_ready  : output stream handshake (token visible on dp o_d)
//   flush            : end-of-stream request, closes an open zero run
//   f_*              : datapath status flags
//   sel_o_d, sel_cnt : datapath output mux and count register selects
//   state, run_open  : FSM status
interface zle_xc9_fsm_if;
  localparam int unsigned SEL_CNT_W = 2;
  localparam int unsigned STATE_W   = 2;

  logic                 i_valid;
  logic                 i_ready;
  logic                 o_valid;
  logic                 o_ready;
  logic                 flush;
  logic                 f_start_i_eq_0;
  logic                 f_zeros_i_eq_0;
  logic                 f_zeros_t_cnt_eq_15;
  logic                 sel_o_d;
  logic [SEL_CNT_W-1:0] sel_cnt;
  logic [STATE_W-1:0]   state;
  logic                 run_open;

  // Environment side: stream fabric plus datapath flag source.
  modport master (
    output i_valid, o_ready, flush,
    output f_start_i_eq_0, f_zeros_i_eq_0, f_zeros_t_cnt_eq_15,
    input  i_ready, o_valid, sel_o_d, sel_cnt, state, run_open
  );

  // FSM side.
  modport slave (
    input  i_valid, o_ready, flush,
    input  f_start_i_eq_0, f_zeros_i_eq_0, f_zeros_t_cnt_eq_15,
    output i_ready, o_valid, sel_o_d, sel_cnt, state, run_open
  );
endinterface

// File: rtl/zle_xc9_fsm.sv
// Control FSM for the zero run-length encoder datapath zle_xc9_dp.
// Decides, each cycle, which token the datapath presents (input value or
// run token 16|cnt), how the run counter moves, and the stream handshakes.
// Handshake and select outputs are Mealy: they must answer within the same
// cycle as the input token so that a token costs zero cycles of latency.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : zle_xc9_fsm_if.slave (handshakes, flags, selects, status)
module zle_xc9_fsm (
  input  logic         clock,
  input  logic         reset,
  zle_xc9_fsm_if.slave bus
);
  localparam int unsigned SEL_CNT_W = 2;

  typedef enum logic [1:0] {
    ST_START   = 2'd0,
    ST_ZEROS   = 2'd1,
    ST_PENDING = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  localparam logic [SEL_CNT_W-1:0] CNT_HOLD  = SEL_CNT_W'(0);
  localparam logic [SEL_CNT_W-1:0] CNT_LOAD1 = SEL_CNT_W'(1);
  localparam logic [SEL_CNT_W-1:0] CNT_CLEAR = SEL_CNT_W'(2);
  localparam logic [SEL_CNT_W-1:0] CNT_INC   = SEL_CNT_W'(3);

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_i_ready;
  logic                  w_o_valid;
  logic                  w_sel_o_d;
  logic [SEL_CNT_W-1:0]  w_sel_cnt;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_START;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and Mealy outputs. A stalled output leaves everything at the
  // defaults (hold count, hold state, no consume) because each branch only
  // commits when o_ready is high.
  always_comb begin
    w_i_ready    = 1'b0;
    w_o_valid    = 1'b0;
    w_sel_o_d    = 1'b0;
    w_sel_cnt    = CNT_HOLD;
    w_next_state = r_state;

    if (reset) begin
      // Clear the datapath count on the same edge the state returns to START.
      w_sel_cnt    = CNT_CLEAR;
      w_next_state = ST_START;
    end else begin
      case (r_state)
        ST_ZEROS: begin
          if (bus.i_valid) begin
            if (bus.f_zeros_i_eq_0 && !bus.f_zeros_t_cnt_eq_15) begin
              w_i_ready = 1'b1;
              w_sel_cnt = CNT_INC;
            end else if (bus.f_zeros_i_eq_0) begin
              // Run is full: emit it and let this zero open the next run.
              w_o_valid = 1'b1;
              w_sel_o_d = 1'b1;
              if (bus.o_ready) begin
                w_i_ready = 1'b1;
                w_sel_cnt = CNT_LOAD1;
              end
            end else begin
              // Nonzero closes the run; the value itself stays at the head
              // of the input and goes out from PENDING.
              w_o_valid = 1'b1;
              w_sel_o_d = 1'b1;
              if (bus.o_ready) begin
                w_sel_cnt    = CNT_CLEAR;
                w_next_state = ST_PENDING;
              end
            end
          end else if (bus.flush) begin
            w_o_valid = 1'b1;
            w_sel_o_d = 1'b1;
            if (bus.o_ready) begin
              w_sel_cnt    = CNT_CLEAR;
              w_next_state = ST_START;
            end
          end
        end

        ST_PENDING: begin
          if (bus.i_valid) begin
            w_o_valid = 1'b1;
            w_i_ready = bus.o_ready;
            if (bus.o_ready) begin
              w_next_state = ST_START;
            end
          end
        end

        default: begin
          // START, and the unused encoding which recovers to START.
          w_next_state = ST_START;
          if (bus.i_valid) begin
            if (bus.f_start_i_eq_0) begin
              w_i_ready    = 1'b1;
              w_sel_cnt    = CNT_LOAD1;
              w_next_state = ST_ZEROS;
            end else begin
              w_o_valid = 1'b1;
              w_i_ready = bus.o_ready;
            end
          end
        end
      endcase
    end
  end

  assign bus.i_ready  = w_i_ready;
  assign bus.o_valid  = w_o_valid;
  assign bus.sel_o_d  = w_sel_o_d;
  assign bus.sel_cnt  = w_sel_cnt;
  assign bus.state    = 2'(r_state);
  assign bus.run_open = (r_state == ST_ZEROS);

endmodule

// File: tb/tb_zle_xc9_fsm.sv
// Bench for zle_xc9_fsm: a run-length model (open run length + pending
// nonzero) predicts every control output each cycle; a small datapath model
// driven by the DUT selects reconstructs output tokens, which are compared
// against hand-computed token lists per scenario.
module tb_zle_xc9_fsm;
  logic clock;
  logic reset;
  zle_xc9_fsm_if bus ();

  zle_xc9_fsm dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Input data at the head of stream i (what the datapath sees on i_d).
  logic [3:0] din = 4'd0;

  // Datapath model: count register steered by the DUT's sel_cnt.
  logic [3:0] dp_cnt = 4'd0;
  always @(posedge clock) begin
    case (bus.sel_cnt)
      2'd1:    dp_cnt <= 4'd1;
      2'd2:    dp_cnt <= 4'd0;
      2'd3:    dp_cnt <= dp_cnt + 4'd1;
      default: dp_cnt <= dp_cnt;
    endcase
  end
  assign bus.f_start_i_eq_0      = (din == 4'd0);
  assign bus.f_zeros_i_eq_0      = (din == 4'd0);
  assign bus.f_zeros_t_cnt_eq_15 = (dp_cnt == 4'd15);

  // Behavioural encoder model: length of the open zero run (0 = none) and
  // whether a nonzero value is owed after an emitted run token.
  int run_len = 0;
  bit pend    = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      run_len <= 0;
      pend    <= 1'b0;
    end else if (pend) begin
      if (bus.i_valid && bus.o_ready) pend <= 1'b0;
    end else if (run_len > 0) begin
      if (bus.i_valid) begin
        if (din == 4'd0) begin
          if (run_len < 15) run_len <= run_len + 1;
          else if (bus.o_ready) run_len <= 1;
        end else if (bus.o_ready) begin
          run_len <= 0;
          pend    <= 1'b1;
        end
      end else if (bus.flush && bus.o_ready) begin
        run_len <= 0;
      end
    end else if (bus.i_valid && din == 4'd0) begin
      run_len <= 1;
    end
  end

  // Expected outputs from the model.
  int e_ir, e_ov, e_sel, e_cnt, e_state;
  always @* begin
    e_ir = 0; e_ov = 0; e_sel = 0; e_cnt = 0;
    e_state = pend ? 2 : (run_len > 0 ? 1 : 0);
    if (reset) begin
      e_cnt = 2;
    end else if (pend) begin
      if (bus.i_valid) begin
        e_ov = 1;
        e_ir = int'(bus.o_ready);
      end
    end else if (run_len > 0) begin
      if (bus.i_valid && din == 4'd0 && run_len < 15) begin
        e_ir = 1; e_cnt = 3;
      end else if (bus.i_valid && din == 4'd0) begin
        e_ov = 1; e_sel = 1;
        if (bus.o_ready) begin e_ir = 1; e_cnt = 1; end
      end else if (bus.i_valid || bus.flush) begin
        e_ov = 1; e_sel = 1;
        if (bus.o_ready) e_cnt = 2;
      end
    end else if (bus.i_valid) begin
      if (din == 4'd0) begin
        e_ir = 1; e_cnt = 1;
      end else begin
        e_ov = 1;
        e_ir = int'(bus.o_ready);
      end
    end
  end

  // Per-cycle compare of all control outputs against the model.
  always @(negedge clock) begin
    chk("i_ready",  int'(bus.i_ready),  e_ir);
    chk("o_valid",  int'(bus.o_valid),  e_ov);
    chk("sel_o_d",  int'(bus.sel_o_d),  e_sel);
    chk("sel_cnt",  int'(bus.sel_cnt),  e_cnt);
    chk("state",    int'(bus.state),    e_state);
    chk("run_open", int'(bus.run_open), int'(e_state == 1));
  end

  // Token scoreboard: every output transfer must match the next listed token.
  int exp_q[$];
  always @(posedge clock) begin
    if (!reset && bus.o_valid && bus.o_ready) begin
      int tok;
      tok = bus.sel_o_d ? (16 + int'(dp_cnt)) : int'(din);
      if (exp_q.size() == 0) chk("token_unexpected", tok, -1);
      else chk("token", tok, exp_q.pop_front());
    end
  end

  // One cycle of stimulus; returns just after the sampling edge.
  task automatic cyc(input bit v, input int d, input bit ordy, input bit fl, input bit rst);
    @(posedge clock); #1;
    bus.i_valid = v;
    din         = 4'(d);
    bus.o_ready = ordy;
    bus.flush   = fl;
    reset       = rst;
    @(negedge clock); #1;
  endtask

  task automatic end_scenario(input string name);
    cyc(0, 0, 1, 0, 0);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    bus.flush   = 1'b0;
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 0);
    chk("pin_reset_state", int'(bus.state), 0);
    chk("pin_reset_run_open", int'(bus.run_open), 0);

    // Two nonzero values stream straight through.
    exp_q = '{3, 5};
    cyc(1, 3, 1, 0, 0);
    chk("pin_pass_i_ready", int'(bus.i_ready), 1);
    cyc(1, 5, 1, 0, 0);
    chk("pin_pass_state", int'(bus.state), 0);
    end_scenario("q_pass");

    // Zero run of 3 then nonzero 4: run token 16|3 then 4.
    exp_q = '{19, 4};
    cyc(1, 0, 1, 0, 0);
    chk("pin_run_load", int'(bus.sel_cnt), 1);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 4, 1, 0, 0);
    chk("pin_close_sel_cnt", int'(bus.sel_cnt), 2);
    chk("pin_close_i_ready", int'(bus.i_ready), 0);
    cyc(1, 4, 1, 0, 0);
    chk("pin_pend_state", int'(bus.state), 2);
    chk("pin_pend_i_ready", int'(bus.i_ready), 1);
    end_scenario("q_run3");

    // 16 zeros then 7: full run 16|15, new run 16|1, then 7.
    exp_q = '{31, 17, 7};
    for (int k = 0; k < 15; k++) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("pin_full_sel_cnt", int'(bus.sel_cnt), 1);
    chk("pin_full_i_ready", int'(bus.i_ready), 1);
    chk("pin_full_state", int'(bus.state), 1);
    cyc(1, 7, 1, 0, 0);
    cyc(1, 7, 1, 0, 0);
    end_scenario("q_full");

    // Backpressure on run token, then on the pending value, then i_valid gap.
    exp_q = '{18, 9};
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 9, 0, 0, 0);
      chk("pin_stall_sel_cnt", int'(bus.sel_cnt), 0);
    end
    cyc(1, 9, 1, 0, 0);
    cyc(1, 9, 0, 0, 0);
    cyc(0, 9, 1, 0, 0);
    cyc(1, 9, 1, 0, 0);
    end_scenario("q_bp");

    // Flush ignored while data valid, stalls, then closes run 16|2.
    exp_q = '{18};
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    chk("pin_flush_sel_cnt", int'(bus.sel_cnt), 2);
    cyc(0, 0, 1, 1, 0);
    chk("pin_flush_start_o_valid", int'(bus.o_valid), 0);
    end_scenario("q_flush");

    // Reset while stalled in PENDING drops the owed value.
    exp_q = '{17};
    cyc(1, 0, 1, 0, 0);
    cyc(1, 6, 1, 0, 0);
    cyc(1, 6, 0, 0, 1);
    chk("pin_rst_o_valid", int'(bus.o_valid), 0);
    chk("pin_rst_sel_cnt", int'(bus.sel_cnt), 2);
    cyc(0, 0, 1, 0, 0);
    chk("pin_rst_after_state", int'(bus.state), 0);
    end_scenario("q_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
